// File: rtl/mmio_uart_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_uart_bridge_if                                                  |
// | Core byte-bus and UART-side signal bundle for the MMIO UART bridge.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mmio_uart_bridge_if;
   logic        rdy_in;
   logic [31:0] mem_a;
   logic [7:0]  mem_dout;
   logic        mem_wr;
   logic [7:0]  io_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_pop;
   logic        program_stop;
   logic        tx_overflow;

   modport slave (
      input  rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
      output io_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop, tx_overflow
   );

   modport master (
      output rdy_in, mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
      input  io_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_stop, tx_overflow
   );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_uart_bridge                                                     |
// | I/O window decode, TX FIFO toward the UART, RX and cycle-counter     |
// | reads, back-pressure and program-stop indication.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mmio_uart_bridge #(
   parameter int FIFO_AW     = 4,
   parameter int FULL_MARGIN = 2
) (
   input  wire logic           clk_in,
   input  wire logic           rst_in,
   mmio_uart_bridge_if.slave   bus
);
   localparam int                 c_depth   = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   c_depth_v = (FIFO_AW+1)'(c_depth);
   localparam logic [FIFO_AW:0]   c_margin  = (FIFO_AW+1)'(FULL_MARGIN);

   logic [7:0]         r_mem [c_depth];
   logic [FIFO_AW-1:0] r_rd_ptr;
   logic [FIFO_AW-1:0] r_wr_ptr;
   logic [FIFO_AW:0]   r_count;
   logic               r_full;
   logic               r_overflow;
   logic               r_stop_pending;
   logic               r_program_stop;
   logic [7:0]         r_io_din;
   logic [31:0]        r_cycle;
   logic [31:0]        r_snapshot;

   logic               w_io_sel;
   logic               w_off4;
   logic               w_wr;
   logic               w_rd;
   logic               w_push_req;
   logic [7:0]         w_push_data;
   logic               w_push;
   logic               w_pop;
   logic               w_tx_valid;
   logic [7:0]         w_head;
   logic [FIFO_AW:0]   w_count_next;
   logic [FIFO_AW:0]   w_free_next;
   logic [7:0]         w_rd_byte;
   logic               w_unused_addr;

   assign w_io_sel      = bus.rdy_in & (bus.mem_a[17:16] == 2'b11);
   assign w_off4        = bus.mem_a[2];
   assign w_wr          = w_io_sel & bus.mem_wr;
   assign w_rd          = w_io_sel & ~bus.mem_wr;
   assign w_unused_addr = ^{bus.mem_a[31:18], bus.mem_a[15:3]};

   // Zero data bytes at offset 0 are dropped; offset 4 always queues the terminator.
   assign w_push_req  = w_wr & ~r_stop_pending & (w_off4 | (bus.mem_dout != 8'h00));
   assign w_push_data = w_off4 ? 8'h00 : bus.mem_dout;

   assign w_tx_valid = (r_count != '0);
   assign w_head     = r_mem[r_rd_ptr];
   assign w_pop      = w_tx_valid & bus.tx_ready;
   assign w_push     = w_push_req & ((r_count != c_depth_v) | w_pop);

   assign w_count_next = r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
   assign w_free_next  = c_depth_v - w_count_next;

   always_comb begin
      w_rd_byte = 8'h00;
      if (!w_off4) begin
         w_rd_byte = bus.rx_valid ? bus.rx_data : 8'h00;
      end else begin
         case (bus.mem_a[1:0])
            2'd0:    w_rd_byte = r_cycle[7:0];
            2'd1:    w_rd_byte = r_snapshot[15:8];
            2'd2:    w_rd_byte = r_snapshot[23:16];
            default: w_rd_byte = r_snapshot[31:24];
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_rd_ptr       <= '0;
         r_wr_ptr       <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_overflow     <= 1'b0;
         r_stop_pending <= 1'b0;
         r_program_stop <= 1'b0;
         r_io_din       <= 8'h00;
         r_cycle        <= 32'h0;
         r_snapshot     <= 32'h0;
      end else begin
         r_cycle <= r_cycle + 32'd1;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
         end
         r_count <= w_count_next;
         r_full  <= (w_free_next <= c_margin);
         if (w_push_req && !w_push) begin
            r_overflow <= 1'b1;
         end
         if (w_push_req && w_off4) begin
            r_stop_pending <= 1'b1;
         end
         // Only the terminator is ever queued as 0x00, so a zero pop ends the program.
         if (w_pop && r_stop_pending && (w_head == 8'h00)) begin
            r_program_stop <= 1'b1;
         end
         if (w_rd) begin
            r_io_din <= w_rd_byte;
            if (w_off4 && (bus.mem_a[1:0] == 2'd0)) begin
               r_snapshot <= r_cycle;
            end
         end
      end
   end

   assign bus.io_din         = r_io_din;
   assign bus.io_buffer_full = r_full;
   assign bus.tx_valid       = w_tx_valid;
   assign bus.tx_data        = w_tx_valid ? w_head : 8'h00;
   assign bus.rx_pop         = w_rd & ~w_off4 & bus.rx_valid;
   assign bus.program_stop   = r_program_stop;
   assign bus.tx_overflow    = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mmio_uart_bridge                                                  |
// | Directed scoreboard bench for the MMIO UART bridge.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_mmio_uart_bridge;
   logic        clk_in;
   logic        rst_in;
   logic [31:0] tb_cnt;
   logic [7:0]  tx_q[$];
   int          checks;
   int          failures;

   mmio_uart_bridge_if bus_i ();

   mmio_uart_bridge #(.FIFO_AW(4), .FULL_MARGIN(2)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus_i)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Reference cycle counter: counts every clock after reset.
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) tb_cnt <= 32'h0;
      else        tb_cnt <= tb_cnt + 32'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every UART handshake must match the oldest queued byte.
   always @(negedge clk_in) begin
      if (!rst_in && bus_i.tx_valid === 1'b1 && bus_i.tx_ready === 1'b1) begin
         if (tx_q.size() == 0) begin
            chk("tx_unexpected", {24'h0, bus_i.tx_data}, 32'hFFFF_FFFF);
         end else begin
            chk("tx_byte", {24'h0, bus_i.tx_data}, {24'h0, tx_q.pop_front()});
         end
      end
   end

   task automatic idle();
      bus_i.rdy_in   = 1'b1;
      bus_i.mem_a    = 32'h0;
      bus_i.mem_dout = 8'h00;
      bus_i.mem_wr   = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [7:0] d);
      bus_i.rdy_in   = 1'b1;
      bus_i.mem_a    = a;
      bus_i.mem_dout = d;
      bus_i.mem_wr   = 1'b1;
      @(posedge clk_in); #1;
      idle();
   endtask

   task automatic rd_set(input logic [31:0] a);
      bus_i.rdy_in = 1'b1;
      bus_i.mem_a  = a;
      bus_i.mem_wr = 1'b0;
   endtask

   initial begin
      int guard;
      logic [7:0] exp_cnt;
      checks = 0;
      failures = 0;
      rst_in = 1'b1;
      idle();
      bus_i.tx_ready = 1'b1;
      bus_i.rx_data  = 8'h00;
      bus_i.rx_valid = 1'b0;

      // Reset state
      repeat (3) @(negedge clk_in);
      chk("rst_tx_valid", {31'h0, bus_i.tx_valid}, 32'h0);
      chk("rst_tx_data", {24'h0, bus_i.tx_data}, 32'h0);
      chk("rst_io_din", {24'h0, bus_i.io_din}, 32'h0);
      chk("rst_flags", {28'h0, bus_i.rx_pop, bus_i.program_stop, bus_i.tx_overflow, bus_i.io_buffer_full}, 32'h0);
      rst_in = 1'b0;

      // Two bytes, one per cycle
      @(negedge clk_in);
      tx_q.push_back(8'h48);
      tx_q.push_back(8'h69);
      wr(32'h0003_0000, 8'h48);
      @(negedge clk_in);
      chk("hi_first_valid", {31'h0, bus_i.tx_valid}, 32'h1);
      chk("hi_first_data", {24'h0, bus_i.tx_data}, 32'h48);
      wr(32'h0003_0000, 8'h69);
      @(negedge clk_in);
      chk("hi_second_data", {24'h0, bus_i.tx_data}, 32'h69);
      @(negedge clk_in);
      chk("hi_drained", {31'h0, bus_i.tx_valid}, 32'h0);

      // Zero byte ignored
      wr(32'h0003_0000, 8'h00);
      @(negedge clk_in);
      chk("zero_no_push", {31'h0, bus_i.tx_valid}, 32'h0);
      chk("zero_no_ovf", {31'h0, bus_i.tx_overflow}, 32'h0);

      // Fill, back-pressure, overflow, drain across wrap
      @(posedge clk_in); #1;
      bus_i.tx_ready = 1'b0;
      for (int i = 0; i < 13; i++) begin
         tx_q.push_back(8'h10 + 8'(i));
         wr(32'h0003_0000, 8'h10 + 8'(i));
      end
      @(negedge clk_in);
      chk("full_at_13", {31'h0, bus_i.io_buffer_full}, 32'h0);
      tx_q.push_back(8'h1D);
      wr(32'h0003_0000, 8'h1D);
      @(negedge clk_in);
      chk("full_at_14", {31'h0, bus_i.io_buffer_full}, 32'h1);
      tx_q.push_back(8'h1E);
      wr(32'h0003_0000, 8'h1E);
      tx_q.push_back(8'h1F);
      wr(32'h0003_0000, 8'h1F);
      @(negedge clk_in);
      chk("ovf_before_17", {31'h0, bus_i.tx_overflow}, 32'h0);
      wr(32'h0003_0000, 8'h99);
      @(negedge clk_in);
      chk("ovf_after_17", {31'h0, bus_i.tx_overflow}, 32'h1);
      chk("full_head", {24'h0, bus_i.tx_data}, 32'h10);
      @(posedge clk_in); #1;
      bus_i.tx_ready = 1'b1;
      guard = 0;
      while (tx_q.size() != 0 && guard < 40) begin
         @(negedge clk_in);
         guard++;
      end
      chk("drain_timeout", 32'(tx_q.size()), 32'h0);
      @(negedge clk_in);
      chk("drain_empty", {31'h0, bus_i.tx_valid}, 32'h0);
      chk("drain_not_full", {31'h0, bus_i.io_buffer_full}, 32'h0);
      chk("ovf_sticky", {31'h0, bus_i.tx_overflow}, 32'h1);

      // Terminator and program stop
      tx_q.push_back(8'h41);
      tx_q.push_back(8'h00);
      wr(32'h0003_0000, 8'h41);
      wr(32'h0003_0004, 8'h01);
      @(negedge clk_in);
      chk("stop_term_data", {24'h0, bus_i.tx_data}, 32'h0);
      chk("stop_before", {31'h0, bus_i.program_stop}, 32'h0);
      @(negedge clk_in);
      chk("stop_after", {31'h0, bus_i.program_stop}, 32'h1);
      wr(32'h0003_0000, 8'h55);
      @(negedge clk_in);
      chk("stop_blocks_push", {31'h0, bus_i.tx_valid}, 32'h0);

      // Coherent cycle-counter snapshot
      guard = 0;
      while (tb_cnt != 32'h1FF && guard < 1000) begin
         @(negedge clk_in);
         guard++;
      end
      chk("cnt_reach_timeout", tb_cnt, 32'h1FF);
      rd_set(32'h0003_0004);
      @(posedge clk_in); #1;
      rd_set(32'h0003_0005);
      @(negedge clk_in);
      chk("cnt_byte0", {24'h0, bus_i.io_din}, 32'hFF);
      @(posedge clk_in); #1;
      rd_set(32'h0003_0006);
      @(negedge clk_in);
      chk("cnt_byte1", {24'h0, bus_i.io_din}, 32'h01);
      @(posedge clk_in); #1;
      rd_set(32'h0003_0007);
      @(negedge clk_in);
      chk("cnt_byte2", {24'h0, bus_i.io_din}, 32'h00);
      @(posedge clk_in); #1;
      idle();
      @(negedge clk_in);
      chk("cnt_byte3", {24'h0, bus_i.io_din}, 32'h00);

      // RX read
      @(posedge clk_in); #1;
      bus_i.rx_valid = 1'b1;
      bus_i.rx_data  = 8'h5A;
      rd_set(32'h0003_0000);
      @(negedge clk_in);
      chk("rx_pop_pulse", {31'h0, bus_i.rx_pop}, 32'h1);
      @(posedge clk_in); #1;
      idle();
      bus_i.rx_valid = 1'b0;
      @(negedge clk_in);
      chk("rx_data", {24'h0, bus_i.io_din}, 32'h5A);
      chk("rx_pop_end", {31'h0, bus_i.rx_pop}, 32'h0);
      @(negedge clk_in);
      chk("io_din_hold", {24'h0, bus_i.io_din}, 32'h5A);

      // Reset clears sticky flags and the counter
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      #2;
      chk("rst2_flags", {30'h0, bus_i.program_stop, bus_i.tx_overflow}, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (3) @(negedge clk_in);
      exp_cnt = tb_cnt[7:0];
      rd_set(32'h0003_0004);
      @(posedge clk_in); #1;
      idle();
      @(negedge clk_in);
      chk("rst2_counter", {24'h0, bus_i.io_din}, {24'h0, exp_cnt});

      // Reset mid-drain discards queued bytes
      @(posedge clk_in); #1;
      bus_i.tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tx_q.push_back(8'hA0 + 8'(i));
         wr(32'h0003_0000, 8'hA0 + 8'(i));
      end
      bus_i.tx_ready = 1'b1;
      repeat (2) @(negedge clk_in);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      tx_q.delete();
      #1;
      chk("mid_rst_tx_valid", {31'h0, bus_i.tx_valid}, 32'h0);
      @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      chk("mid_rst_empty", {31'h0, bus_i.tx_valid}, 32'h0);

      // rdy_in low: bus ignored
      bus_i.rdy_in   = 1'b0;
      bus_i.mem_a    = 32'h0003_0000;
      bus_i.mem_wr   = 1'b0;
      bus_i.rx_valid = 1'b1;
      #1;
      chk("rdy_low_no_pop", {31'h0, bus_i.rx_pop}, 32'h0);
      bus_i.mem_wr   = 1'b1;
      bus_i.mem_dout = 8'h77;
      @(negedge clk_in);
      chk("rdy_low_no_push", {31'h0, bus_i.tx_valid}, 32'h0);
      idle();
      bus_i.rx_valid = 1'b0;
      repeat (2) @(negedge clk_in);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
